// File: rtl/l9_bram1_seq_ctrl.sv
// Layer-9 BRAM1 sequencer: walks LOAD, CONV, WB, OUT and DONE on a start pulse,
// driving the address generator's phase/lane/tap/slot codes and coordinates.
module l9_bram1_seq_ctrl #(
  parameter int XMAX       = 7,
  parameter int YMAX       = 7,
  parameter int KTAPS      = 3,
  parameter int PIPE_DEPTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic [2:0] u,
  output logic [1:0] L,
  output logic [1:0] k,
  output logic [2:0] z,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [3:0] x_Reg5,
  output logic [3:0] y_Reg5,
  output logic       bram_en,
  output logic       bram_we,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_CONV = 3'd2, S_WB = 3'd3, S_OUT = 3'd4, S_DONE = 3'd5
  } state_t;

  localparam logic [3:0] XM = 4'(XMAX);
  localparam logic [3:0] YM = 4'(YMAX);
  localparam logic [1:0] KM = 2'(KTAPS);
  localparam logic [3:0] FM = 4'(PIPE_DEPTH - 1);
  // The output registers form the last delay stage, so only DL internal stages are kept.
  localparam int DL = PIPE_DEPTH - 1;

  function automatic logic [2:0] slot_of(input logic v, input logic [1:0] lane);
    logic [2:0] s;
    if (!v) begin
      s = 3'd7;
    end else begin
      case (lane)
        2'd0:    s = 3'd1;
        2'd1:    s = 3'd2;
        2'd2:    s = 3'd3;
        default: s = 3'd0;
      endcase
    end
    return s;
  endfunction

  state_t     state_r, state_s;
  logic       flush_r, flush_s;
  logic [3:0] fcnt_r, fcnt_s;
  logic       dv_r [DL];
  logic [1:0] dl_r [DL];
  logic [3:0] dx_r [DL];
  logic [3:0] dy_r [DL];
  logic       dv_s [DL];
  logic [1:0] dl_s [DL];
  logic [3:0] dx_s [DL];
  logic [3:0] dy_s [DL];
  logic [2:0] u_s, z_s;
  logic [1:0] l_s, k_s;
  logic [3:0] x_s, y_s, xr_s, yr_s;
  logic       en_s, we_s, busy_s, done_s;

  logic       y_last_s, x_last_s, k_last_s, sweep_end_s;
  logic [1:0] l_inc_s;
  logic [3:0] x_inc_s, y_inc_s;

  assign y_last_s    = (y == YM);
  assign x_last_s    = (x == XM);
  assign k_last_s    = (k == KM);
  assign sweep_end_s = (L == 2'd3) && x_last_s && y_last_s;
  assign y_inc_s     = y_last_s ? 4'd0 : y + 4'd1;
  assign x_inc_s     = y_last_s ? (x_last_s ? 4'd0 : x + 4'd1) : x;
  assign l_inc_s     = (y_last_s && x_last_s) ? L + 2'd1 : L;

  // Next-state and next-output decode for the cycle after the coming edge.
  always_comb begin
    state_s = state_r;
    u_s     = 3'd2;
    l_s     = 2'd0;
    k_s     = 2'd0;
    z_s     = 3'd7;
    x_s     = 4'd0;
    y_s     = 4'd0;
    xr_s    = 4'd0;
    yr_s    = 4'd0;
    en_s    = 1'b0;
    we_s    = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    flush_s = 1'b0;
    fcnt_s  = 4'd0;
    for (int i = 0; i < DL; i++) begin
      dv_s[i] = 1'b0;
      dl_s[i] = 2'd0;
      dx_s[i] = 4'd0;
      dy_s[i] = 4'd0;
    end
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_s = S_LOAD;
          u_s     = 3'd0;
          en_s    = 1'b1;
          we_s    = 1'b1;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        busy_s = 1'b1;
        en_s   = 1'b1;
        if (sweep_end_s) begin
          state_s = S_CONV;
          u_s     = 3'd3;
          k_s     = 2'd1;
        end else begin
          u_s  = 3'd0;
          we_s = 1'b1;
          l_s  = l_inc_s;
          x_s  = x_inc_s;
          y_s  = y_inc_s;
        end
      end
      S_CONV: begin
        busy_s = 1'b1;
        en_s   = 1'b1;
        if (k_last_s && sweep_end_s) begin
          state_s = S_WB;
          u_s     = 3'd4;
        end else if (k_last_s) begin
          u_s = 3'd3;
          k_s = 2'd1;
          l_s = l_inc_s;
          x_s = x_inc_s;
          y_s = y_inc_s;
        end else begin
          u_s = 3'd3;
          k_s = k + 2'd1;
          l_s = L;
          x_s = x;
          y_s = y;
        end
      end
      S_WB: begin
        busy_s  = 1'b1;
        en_s    = 1'b1;
        u_s     = 3'd4;
        dv_s[0] = ~flush_r;
        dl_s[0] = L;
        dx_s[0] = x;
        dy_s[0] = y;
        for (int i = 1; i < DL; i++) begin
          dv_s[i] = dv_r[i-1];
          dl_s[i] = dl_r[i-1];
          dx_s[i] = dx_r[i-1];
          dy_s[i] = dy_r[i-1];
        end
        if (flush_r && (fcnt_r == FM)) begin
          state_s = S_OUT;
          u_s     = 3'd5;
        end else begin
          we_s = dv_r[DL-1];
          z_s  = slot_of(dv_r[DL-1], dl_r[DL-1]);
          xr_s = dx_r[DL-1];
          yr_s = dy_r[DL-1];
          if (flush_r) begin
            flush_s = 1'b1;
            fcnt_s  = fcnt_r + 4'd1;
            l_s     = L;
            x_s     = x;
            y_s     = y;
          end else if (sweep_end_s) begin
            flush_s = 1'b1;
            fcnt_s  = 4'd0;
            l_s     = L;
            x_s     = x;
            y_s     = y;
          end else begin
            l_s = l_inc_s;
            x_s = x_inc_s;
            y_s = y_inc_s;
          end
        end
      end
      S_OUT: begin
        busy_s = 1'b1;
        en_s   = 1'b1;
        if (sweep_end_s) begin
          state_s = S_DONE;
          en_s    = 1'b0;
          done_s  = 1'b1;
        end else begin
          u_s = 3'd5;
          l_s = l_inc_s;
          x_s = x_inc_s;
          y_s = y_inc_s;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, counters, delay line and outputs; a stall freezes all but the enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      flush_r <= 1'b0;
      fcnt_r  <= 4'd0;
      for (int i = 0; i < DL; i++) begin
        dv_r[i] <= 1'b0;
        dl_r[i] <= 2'd0;
        dx_r[i] <= 4'd0;
        dy_r[i] <= 4'd0;
      end
      u       <= 3'd2;
      L       <= 2'd0;
      k       <= 2'd0;
      z       <= 3'd7;
      x       <= 4'd0;
      y       <= 4'd0;
      x_Reg5  <= 4'd0;
      y_Reg5  <= 4'd0;
      bram_en <= 1'b0;
      bram_we <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (stall && (state_r != S_IDLE)) begin
      bram_en <= 1'b0;
      bram_we <= 1'b0;
    end else begin
      state_r <= state_s;
      flush_r <= flush_s;
      fcnt_r  <= fcnt_s;
      for (int i = 0; i < DL; i++) begin
        dv_r[i] <= dv_s[i];
        dl_r[i] <= dl_s[i];
        dx_r[i] <= dx_s[i];
        dy_r[i] <= dy_s[i];
      end
      u       <= u_s;
      L       <= l_s;
      k       <= k_s;
      z       <= z_s;
      x       <= x_s;
      y       <= y_s;
      x_Reg5  <= xr_s;
      y_Reg5  <= yr_s;
      bram_en <= en_s;
      bram_we <= we_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule
